// File: rtl/icache_sa_burst.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | icache_sa_burst                                                            |
// | 2-way set-associative read-only I-cache, burst line refill, fence.i flush. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module icache_sa_burst #(
  parameter int ADDR_W     = 16,
  parameter int INDEX_W    = 6,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              rd,
  input  logic              flush,
  output logic [31:0]       data2cpu,
  output logic              data_ready,
  output logic              hit_miss,
  output logic              busy,
  output logic              mrden,
  output logic [ADDR_W-1:0] m_rd_address,
  input  logic [31:0]       data_in_mem,
  input  logic              mem_valid,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int c_sets   = 2 ** INDEX_W;
  localparam int c_woff_w = $clog2(LINE_WORDS);
  localparam int c_tag_w  = ADDR_W - INDEX_W - c_woff_w - 2;
  localparam int c_depth  = c_sets * LINE_WORDS;

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_refill = 2'd1;
  localparam logic [1:0] c_st_done   = 2'd2;
  localparam logic [1:0] c_st_flush  = 2'd3;

  logic [1:0]          r_state, w_state_next;
  logic [c_sets-1:0]   r_valid0, r_valid1, r_lru;
  logic [c_tag_w-1:0]  r_tag0 [c_sets];
  logic [c_tag_w-1:0]  r_tag1 [c_sets];
  logic [31:0]         r_data0 [c_depth];
  logic [31:0]         r_data1 [c_depth];

  logic [c_woff_w-1:0] w_word, r_req_word, r_beat;
  logic [INDEX_W-1:0]  w_index, r_req_index, r_flush_idx;
  logic [c_tag_w-1:0]  w_tag, r_req_tag;
  logic                w_hit0, w_hit1, w_hit, w_victim, r_victim;
  logic                w_fill, w_last_beat, w_start_hit, w_start_miss;
  logic                r_flush_pending, r_mrden;
  logic [31:0]         w_hit_word, r_data2cpu;
  logic [ADDR_W-1:0]   r_m_rd_address;
  logic [15:0]         r_hit_count, r_miss_count;
  logic                w_unused;

  assign w_word   = address[c_woff_w+1:2];
  assign w_index  = address[c_woff_w+2 +: INDEX_W];
  assign w_tag    = address[ADDR_W-1 -: c_tag_w];
  assign w_unused = &{1'b0, address[1:0]};

  assign w_hit0     = r_valid0[w_index] && (r_tag0[w_index] == w_tag);
  assign w_hit1     = r_valid1[w_index] && (r_tag1[w_index] == w_tag);
  assign w_hit      = w_hit0 || w_hit1;
  assign w_hit_word = w_hit0 ? r_data0[{w_index, w_word}] : r_data1[{w_index, w_word}];

  // Fill an empty way first; only consult lru when both ways hold a line.
  assign w_victim = !r_valid0[w_index] ? 1'b0 :
                    !r_valid1[w_index] ? 1'b1 : r_lru[w_index];

  assign w_fill       = (r_state == c_st_refill) && mem_valid;
  assign w_last_beat  = w_fill && (r_beat == c_woff_w'(LINE_WORDS - 1));
  assign w_start_hit  = (r_state == c_st_idle) && (w_state_next == c_st_done);
  assign w_start_miss = (r_state == c_st_idle) && (w_state_next == c_st_refill);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_st_idle;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (flush || r_flush_pending) w_state_next = c_st_flush;
        else if (rd)                  w_state_next = w_hit ? c_st_done : c_st_refill;
      end
      c_st_refill: if (w_last_beat) w_state_next = c_st_done;
      c_st_done:   w_state_next = c_st_idle;
      c_st_flush:  if (r_flush_idx == {INDEX_W{1'b1}}) w_state_next = c_st_idle;
      default:     w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    hit_miss     = (r_state == c_st_idle) && w_hit;
    busy         = (r_state != c_st_idle);
    data_ready   = (r_state == c_st_done);
    data2cpu     = r_data2cpu;
    mrden        = r_mrden;
    m_rd_address = r_m_rd_address;
    hit_count    = r_hit_count;
    miss_count   = r_miss_count;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid0        <= '0;
      r_valid1        <= '0;
      r_lru           <= '0;
      r_data2cpu      <= '0;
      r_mrden         <= 1'b0;
      r_m_rd_address  <= '0;
      r_hit_count     <= '0;
      r_miss_count    <= '0;
      r_flush_pending <= 1'b0;
      r_flush_idx     <= '0;
      r_beat          <= '0;
      r_req_word      <= '0;
      r_req_index     <= '0;
      r_req_tag       <= '0;
      r_victim        <= 1'b0;
    end else begin
      // A flush seen while busy is deferred; IDLE always drains it into FLUSH.
      if (r_state != c_st_idle && flush) r_flush_pending <= 1'b1;
      else if (r_state == c_st_idle)     r_flush_pending <= 1'b0;

      if (w_start_hit) begin
        r_data2cpu     <= w_hit_word;
        r_lru[w_index] <= w_hit0;
        if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
      end

      if (w_start_miss) begin
        if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
        r_mrden        <= 1'b1;
        r_m_rd_address <= {w_tag, w_index, {(c_woff_w + 2){1'b0}}};
        r_beat         <= '0;
        r_req_word     <= w_word;
        r_req_index    <= w_index;
        r_req_tag      <= w_tag;
        r_victim       <= w_victim;
      end

      if (w_fill) begin
        r_beat <= r_beat + c_woff_w'(1);
        if (r_beat == r_req_word) r_data2cpu <= data_in_mem;
      end

      if (w_last_beat) begin
        r_mrden            <= 1'b0;
        r_lru[r_req_index] <= ~r_victim;
        if (r_victim) r_valid1[r_req_index] <= 1'b1;
        else          r_valid0[r_req_index] <= 1'b1;
      end

      if (r_state == c_st_done) r_data2cpu <= '0;

      if (r_state == c_st_flush) begin
        r_valid0[r_flush_idx] <= 1'b0;
        r_valid1[r_flush_idx] <= 1'b0;
        r_lru[r_flush_idx]    <= 1'b0;
        r_flush_idx           <= r_flush_idx + INDEX_W'(1);
      end
    end
  end

  // Line storage carries no reset; the valid bits guard every lookup.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      if (r_victim) r_data1[{r_req_index, r_beat}] <= data_in_mem;
      else          r_data0[{r_req_index, r_beat}] <= data_in_mem;
    end
    if (w_last_beat) begin
      if (r_victim) r_tag1[r_req_index] <= r_req_tag;
      else          r_tag0[r_req_index] <= r_req_tag;
    end
  end

endmodule
`default_nettype wire
